// File: rtl/mii_frame_generator.sv
// mii_frame_generator: self-running MII transmit source looping idle gap, start, payload, terminate (clk/i_rst in; o_tx_data/o_tx_ctrl registered out)
module mii_frame_generator #(
  parameter int          DATA_WIDTH  = 64,
  parameter int          CTRL_WIDTH  = 1,
  parameter int          IDLE_LENGTH = 16,
  parameter int          DATA_LENGTH = 64,
  parameter logic [7:0]  IDLE_CODE   = 8'h07,
  parameter logic [7:0]  START_CODE  = 8'hFB,
  parameter logic [7:0]  EOF_CODE    = 8'hFD
) (
  input  logic                  clk,
  input  logic                  i_rst,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl
);
  localparam int N       = DATA_WIDTH / 8;
  localparam int MAX_LEN = IDLE_LENGTH > DATA_LENGTH ? IDLE_LENGTH : DATA_LENGTH;
  localparam int CW      = $clog2(MAX_LEN) + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, EOF} state_t;
  state_t                state, state_d;
  logic [CW-1:0]         cnt;
  logic [7:0]            bcnt;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  ctrl_d;
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bcnt      <= '0;
      o_tx_data <= {N{IDLE_CODE}};
      o_tx_ctrl <= '1;
    end else begin
      state     <= state_d;
      cnt       <= state_d != state ? '0 : cnt + CW'(1);
      bcnt      <= state == DATA ? bcnt + 8'(N) : '0;
      o_tx_data <= data_d;
      o_tx_ctrl <= {CTRL_WIDTH{ctrl_d}};
    end
  end
  always_comb begin
    state_d = state == IDLE  ? (cnt == CW'(IDLE_LENGTH - 1) ? START : IDLE) :
              state == START ? DATA :
              state == DATA  ? (cnt == CW'(DATA_LENGTH - 1) ? EOF : DATA) :
                               IDLE;
  end
  always_comb begin
    data_d = {N{IDLE_CODE}};
    ctrl_d = 1'b1;
    if (state == START)
      data_d = {{(N-1){8'h55}}, START_CODE};
    else if (state == EOF)
      data_d = {{(N-1){IDLE_CODE}}, EOF_CODE};
    else if (state == DATA) begin
      ctrl_d = 1'b0;
      for (int j = 0; j < N; j++)
        data_d[8*j +: 8] = bcnt + 8'(j);
    end
  end
endmodule

// File: tb/tb_mii_frame_generator.sv
// tb_mii_frame_generator: directed checks of frame sequence, reset abort and long-run character totals
module tb_mii_frame_generator;
  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [63:0] o_tx_data;
  logic [0:0]  o_tx_ctrl;
  int          checks = 0;
  int          failures = 0;
  int          data_chars = 0;
  int          ctrl_chars = 0;
  int          x_samples = 0;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'h55555555555555FB;
  localparam logic [63:0] EOF_W = 64'h07070707070707FD;
  localparam logic [63:0] PAY0_W = 64'h0706050403020100;
  localparam logic [63:0] PAY1_W = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] PAYW_W = 64'hFFFEFDFCFBFAF9F8;
  mii_frame_generator dut (
    .clk(clk),
    .i_rst(i_rst),
    .o_tx_data(o_tx_data),
    .o_tx_ctrl(o_tx_ctrl)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] d, input logic c);
    checks++;
    assert (o_tx_data === d && o_tx_ctrl === c) else begin
      failures++;
      $error("FAIL %s: got data=%h ctrl=%b, expected data=%h ctrl=%b", tag, o_tx_data, o_tx_ctrl, d, c);
    end
  endtask
  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    i_rst = 1'b1;
    tick();
    tick();
    check("reset_word", IDLE_W, 1'b1);
    i_rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      check($sformatf("idle_e%0d", n), IDLE_W, 1'b1);
    end
    tick();
    check("start_e17", START_W, 1'b1);
    tick();
    check("pay_e18", PAY0_W, 1'b0);
    tick();
    check("pay_e19", PAY1_W, 1'b0);
    for (int n = 20; n <= 49; n++) tick();
    check("pay_e49_wrap", PAYW_W, 1'b0);
    for (int n = 50; n <= 81; n++) tick();
    check("pay_e81_last", PAYW_W, 1'b0);
    tick();
    check("eof_e82", EOF_W, 1'b1);
    for (int n = 83; n <= 98; n++) begin
      tick();
      check($sformatf("idle_e%0d", n), IDLE_W, 1'b1);
    end
    tick();
    check("start_e99", START_W, 1'b1);
    tick();
    check("pay_e100", PAY0_W, 1'b0);
    for (int n = 101; n <= 121; n++) tick();
    i_rst = 1'b1;
    tick();
    check("abort_reset_word", IDLE_W, 1'b1);
    i_rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      check($sformatf("abort_idle_%0d", n), IDLE_W, 1'b1);
    end
    tick();
    check("abort_start", START_W, 1'b1);
    tick();
    check("abort_pay0", PAY0_W, 1'b0);
    tick();
    check("abort_pay1", PAY1_W, 1'b0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      tick();
      if ($isunknown(o_tx_data) || $isunknown(o_tx_ctrl)) x_samples++;
      if (o_tx_ctrl === 1'b0) data_chars += 8;
      else ctrl_chars += 8;
    end
    check_int("long_data_chars", data_chars, 12408);
    check_int("long_ctrl_chars", ctrl_chars, 3592);
    check_int("long_x_samples", x_samples, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
